// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants for the register write-back slice.
// No logic; imported by the write-back top and its NZP/BEN sub-module.
package lc3_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam logic [REG_IDX_W-1:0] R7_IDX = 3'd7;

    typedef enum logic {
        DR_IR11_9 = 1'b0,
        DR_R7     = 1'b1
    } drmux_t;

    typedef enum logic {
        SR1_IR11_9 = 1'b0,
        SR1_IR8_6  = 1'b1
    } sr1mux_t;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } nzp_t;

endpackage

// File: rtl/lc3_nzp_ben.sv
// NZP condition-code register and BEN latch; both update one Clk edge after their strobe.
// No handshake: strobes are always accepted, and BEN evaluates against the pre-edge NZP.
module lc3_nzp_ben
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_al_i,
    input  logic [DATA_W-1:0] bus_i,
    input  logic [2:0]        cond_i,
    input  logic              ld_cc_i,
    input  logic              ld_ben_i,
    output nzp_t              nzp_o,
    output logic              ben_o
);

    nzp_t nzp_q, nzp_d, nzp_bus;
    logic ben_q, ben_d;

    always_comb begin
        nzp_bus.n = bus_i[DATA_W-1];
        nzp_bus.z = (bus_i == '0);
        nzp_bus.p = ~nzp_bus.n & ~nzp_bus.z;
    end

    always_comb begin
        nzp_d = nzp_q;
        ben_d = ben_q;
        if (ld_cc_i) begin
            nzp_d = nzp_bus;
        end
        // Old NZP on purpose: a BR decode that also loads CC tests the previous result.
        if (ld_ben_i) begin
            ben_d = (cond_i[2] & nzp_q.n) | (cond_i[1] & nzp_q.z) | (cond_i[0] & nzp_q.p);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_al_i) begin
            nzp_q <= '0;
            ben_q <= 1'b0;
        end else begin
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

    assign nzp_o = nzp_q;
    assign ben_o = ben_q;

endmodule

// File: rtl/lc3_reg_writeback.sv
// LC-3 8x16 register file with SR1/SR2 read ports, NZP and BEN; writes land one Clk edge later.
// Reads are combinational from stored state (no bypass); no handshake, strobes always accepted.
module lc3_reg_writeback
    import lc3_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic              Clk,
    input  logic              Reset_al,
    input  logic [DATA_W-1:0] Bus,
    input  logic [15:0]       IR,
    input  logic              LD_REG,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    output logic [DATA_W-1:0] SR1_out,
    output logic [DATA_W-1:0] SR2_out,
    output logic [2:0]        NZP,
    output logic              BEN
);

    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [REG_IDX_W-1:0] dr_idx;
    logic [REG_IDX_W-1:0] sr1_idx;
    logic [REG_IDX_W-1:0] sr2_idx;
    drmux_t               dr_sel;
    sr1mux_t              sr1_sel;
    nzp_t                 nzp;
    logic                 unused_ir;

    // Opcode and the SR2 immediate-mode bits are decoded elsewhere.
    assign unused_ir = ^{IR[15:12], IR[5:3]};

    assign dr_sel  = drmux_t'(DRMUX);
    assign sr1_sel = sr1mux_t'(SR1MUX);
    assign dr_idx  = (dr_sel == DR_R7) ? R7_IDX : IR[11:9];
    assign sr1_idx = (sr1_sel == SR1_IR8_6) ? IR[8:6] : IR[11:9];
    assign sr2_idx = IR[2:0];

    always_comb begin
        regs_d = regs_q;
        if (LD_REG) begin
            regs_d[dr_idx] = Bus;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign SR1_out = regs_q[sr1_idx];
    assign SR2_out = regs_q[sr2_idx];

    lc3_nzp_ben #(
        .DATA_W (DATA_W)
    ) u_nzp_ben (
        .clk_i      (Clk),
        .reset_al_i (Reset_al),
        .bus_i      (Bus),
        .cond_i     (IR[11:9]),
        .ld_cc_i    (LD_CC),
        .ld_ben_i   (LD_BEN),
        .nzp_o      (nzp),
        .ben_o      (BEN)
    );

    assign NZP = nzp;

endmodule

// File: tb/tb_lc3_reg_writeback.sv
// Directed bench for lc3_reg_writeback: reset, read/write, DRMUX, condition codes, BEN, reset priority.
module tb_lc3_reg_writeback;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic [15:0] Bus;
    logic [15:0] IR;
    logic        LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX;
    logic [15:0] SR1_out, SR2_out;
    logic [2:0]  NZP;
    logic        BEN;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    lc3_reg_writeback dut (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .Bus      (Bus),
        .IR       (IR),
        .LD_REG   (LD_REG),
        .LD_CC    (LD_CC),
        .LD_BEN   (LD_BEN),
        .DRMUX    (DRMUX),
        .SR1MUX   (SR1MUX),
        .SR1_out  (SR1_out),
        .SR2_out  (SR2_out),
        .NZP      (NZP),
        .BEN      (BEN)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive at the falling edge so inputs are stable well before the next rising edge.
    task automatic drive(input logic rst_al, input logic [15:0] bus_v, input logic [15:0] ir_v,
                         input logic ld_reg, input logic ld_cc, input logic ld_ben,
                         input logic drm, input logic sr1m);
        @(negedge Clk);
        Reset_al = rst_al;
        Bus      = bus_v;
        IR       = ir_v;
        LD_REG   = ld_reg;
        LD_CC    = ld_cc;
        LD_BEN   = ld_ben;
        DRMUX    = drm;
        SR1MUX   = sr1m;
    endtask

    task automatic edge_settle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] ir_v, input logic sr1m);
        drive(1'b1, 16'h0000, ir_v, 1'b0, 1'b0, 1'b0, 1'b0, sr1m);
    endtask

    function automatic logic [15:0] mk_ir(input logic [2:0] f11, input logic [2:0] f8,
                                          input logic [2:0] f2);
        return {4'b0001, f11, f8, 3'b000, f2};
    endfunction

    logic [15:0] cc_bus [4];
    logic [2:0]  cc_exp [4];

    initial begin
        cc_bus[0] = 16'h0000; cc_exp[0] = 3'b010;
        cc_bus[1] = 16'h8000; cc_exp[1] = 3'b100;
        cc_bus[2] = 16'h7FFF; cc_exp[2] = 3'b001;
        cc_bus[3] = 16'hFFFF; cc_exp[3] = 3'b100;

        // Power-on reset
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        edge_settle();

        // Preload R3 = 1234 with NZP = 001, then reset for one edge
        drive(1'b1, 16'h1234, mk_ir(3'd3, 3'd0, 3'd3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        edge_settle();
        idle(mk_ir(3'd3, 3'd0, 3'd3), 1'b0);
        #1;
        chk("preload_r3", SR2_out, 16'h1234);
        chk("preload_nzp", {13'd0, NZP}, 16'h0001);
        drive(1'b0, 16'h0000, mk_ir(3'd3, 3'd0, 3'd3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        idle(mk_ir(3'd3, 3'd0, 3'd3), 1'b0);
        #1;
        chk("rst_sr1", SR1_out, 16'h0000);
        chk("rst_sr2", SR2_out, 16'h0000);
        chk("rst_nzp", {13'd0, NZP}, 16'h0000);
        chk("rst_ben", {15'd0, BEN}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            idle(mk_ir(3'd0, 3'd0, 3'(i)), 1'b0);
            #1;
            chk($sformatf("rst_r%0d", i), SR2_out, 16'h0000);
        end

        // Write R5 = BEEF; old value visible until the edge
        drive(1'b1, 16'hBEEF, mk_ir(3'd5, 3'd0, 3'd5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wr_same_cycle_sr1", SR1_out, 16'h0000);
        chk("wr_same_cycle_sr2", SR2_out, 16'h0000);
        edge_settle();
        chk("wr_sr1_r5", SR1_out, 16'hBEEF);
        chk("wr_sr2_r5", SR2_out, 16'hBEEF);
        idle(mk_ir(3'd0, 3'd5, 3'd4), 1'b1);
        #1;
        chk("wr_sr1mux_ir8_6_r5", SR1_out, 16'hBEEF);
        chk("wr_r4_untouched", SR2_out, 16'h0000);

        // DRMUX=1 writes R7, leaves R[IR[11:9]] alone
        drive(1'b1, 16'h3001, mk_ir(3'd5, 3'd0, 3'd7), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        edge_settle();
        chk("jsr_r7", SR2_out, 16'h3001);
        chk("jsr_r5_kept", SR1_out, 16'hBEEF);

        // LD_REG=0 holds registers
        drive(1'b1, 16'h5A5A, mk_ir(3'd5, 3'd0, 3'd7), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        chk("noload_r5", SR1_out, 16'hBEEF);
        chk("noload_r7", SR2_out, 16'h3001);

        // Condition codes
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, cc_bus[i], mk_ir(3'd0, 3'd0, 3'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            edge_settle();
            chk($sformatf("cc_%h", cc_bus[i]), {13'd0, NZP}, {13'd0, cc_exp[i]});
        end
        drive(1'b1, 16'h0000, mk_ir(3'd0, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        chk("cc_hold", {13'd0, NZP}, 16'h0004);

        // BEN: NZP = 010 first
        drive(1'b1, 16'h0000, mk_ir(3'd0, 3'd0, 3'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        edge_settle();
        drive(1'b1, 16'h0000, mk_ir(3'b010, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_settle();
        chk("ben_z_match", {15'd0, BEN}, 16'h0001);
        drive(1'b1, 16'h0000, mk_ir(3'b101, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_settle();
        chk("ben_np_nomatch", {15'd0, BEN}, 16'h0000);
        drive(1'b1, 16'h0000, mk_ir(3'b010, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_settle();
        chk("ben_hold", {15'd0, BEN}, 16'h0000);
        drive(1'b1, 16'h8000, mk_ir(3'b100, 3'd0, 3'd0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        edge_settle();
        chk("ben_uses_old_nzp", {15'd0, BEN}, 16'h0000);
        chk("ben_cc_updated", {13'd0, NZP}, 16'h0004);
        drive(1'b1, 16'h0000, mk_ir(3'b100, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_settle();
        chk("ben_n_match", {15'd0, BEN}, 16'h0001);

        // Reset beats every strobe
        drive(1'b0, 16'h5555, mk_ir(3'b111, 3'd0, 3'd5), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        edge_settle();
        idle(mk_ir(3'd7, 3'd0, 3'd5), 1'b0);
        #1;
        chk("rstpri_r5", SR2_out, 16'h0000);
        chk("rstpri_r7", SR1_out, 16'h0000);
        chk("rstpri_nzp", {13'd0, NZP}, 16'h0000);
        chk("rstpri_ben", {15'd0, BEN}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_reg_writeback.md
Name: lc3_reg_writeback

Overview:
- Write-back end of the LC-3 datapath: the side that feeds SR1_out/SR2_out to the ALU and accepts its result (and every other bus driver) back off the bus.
- Holds the 8x16 general register file, the NZP condition-code register and the BEN branch-enable latch.
- Driven by the control FSM through LD_REG, LD_CC, LD_BEN, DRMUX and SR1MUX.
- Sits between the bus mux and the ALU; all state updates on the rising edge of Clk.

Parameters:
- DATA_W, 16, register, bus and read-port width.
- NUM_REGS, 8, number of general registers; fixed at 8 because the IR register fields are 3 bits. Other values are unsupported.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_al  in  1  synchronous, active-low reset; sampled on the Clk rising edge.
- Bus  in  DATA_W  shared datapath bus (ALU, MDR, PC, MARMUX).
- IR  in  16  current instruction register.
- LD_REG  in  1  write Bus into the destination register.
- LD_CC  in  1  update NZP from Bus.
- LD_BEN  in  1  latch the branch-enable result.
- DRMUX  in  1  destination select: 0 = IR[11:9], 1 = R7.
- SR1MUX  in  1  SR1 index select: 0 = IR[11:9], 1 = IR[8:6].
- SR1_out  out  DATA_W  contents of the selected SR1 register.
- SR2_out  out  DATA_W  contents of R[IR[2:0]].
- NZP  out  3  condition codes {N,Z,P}.
- BEN  out  1  latched branch enable.

Behaviour:
- Reset (Reset_al=0 at a Clk edge):
  - R0..R7 <= 0; NZP <= 3'b000; BEN <= 0.
  - Reset wins over every simultaneous LD_* strobe.
  - After reset, SR1_out = SR2_out = 0.
  - Reset asserted mid-sequence discards any pending write.
- Reads:
  - Combinational from the stored registers: SR1_out = R[sr1_idx], SR2_out = R[IR[2:0]].
  - No write-through bypass. A write at edge k is visible on the read ports only after edge k (same-cycle read returns the old value).
- Write:
  - LD_REG=1 at an edge: R[dr_idx] <= Bus, with dr_idx = DRMUX ? 3'd7 : IR[11:9].
  - Exactly one register changes per write.
  - LD_REG=0 leaves all registers unchanged.
- Condition codes on LD_CC=1:
  - N = Bus[15]; Z = (Bus == 0); P = ~N & ~Z.
  - Exactly one bit is set after any LD_CC. 16'h8000 gives 100; 16'h7FFF gives 001.
  - LD_CC=0 holds NZP.
- BEN on LD_BEN=1: BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the registered NZP value before the edge.
  - If LD_CC and LD_BEN are asserted together, BEN uses the old NZP.
  - LD_BEN=0 holds BEN.
- Simultaneous strobes:
  - LD_REG and LD_CC together both take effect in the same edge from the same Bus value (normal LC-3 ADD/AND/NOT/LD write-back).
  - Latency: one edge for every update; no multi-cycle operations and no handshake.
- X-safety: DRMUX and SR1MUX are 1-bit, so every encoding is defined.

Decomposition:
- Shared package lc3_pkg holds:
  - DATA_W = 16, REG_IDX_W = 3, R7_IDX = 3'd7.
  - Enum drmux_t {DR_IR11_9, DR_R7}.
  - Enum sr1mux_t {SR1_IR11_9, SR1_IR8_6}.
  - Typedef nzp_t (packed struct n, z, p).
- One natural sub-module: lc3_nzp_ben, owning the NZP register, Bus-to-NZP derivation and the BEN latch.
- The register array and the read/write index muxes stay in lc3_reg_writeback.

Test Plan:
- Reset: preload R3=16'h1234 and NZP=001, assert Reset_al=0 for one edge -> all regs 0, NZP=000, BEN=0, SR1_out=SR2_out=0.
- Write/read: IR[11:9]=5, DRMUX=0, LD_REG=1, Bus=16'hBEEF. Then SR1MUX=0, IR[2:0]=5 -> SR1_out=SR2_out=16'hBEEF one edge later; old value visible in the same cycle.
- DRMUX=1 (JSR path): Bus=16'h3001, LD_REG=1 -> R7=16'h3001; R[IR[11:9]] unchanged.
- Condition codes: LD_CC with Bus = 0000, 8000, 7FFF, FFFF -> NZP = 010, 100, 001, 100.
- BEN:
  - NZP=010, IR[11:9]=010, LD_BEN -> BEN=1.
  - IR[11:9]=101 -> BEN=0.
  - With LD_CC (Bus=8000) and LD_BEN together, IR[11:9]=100, old NZP=010 -> BEN=0, NZP=100.
- Reset priority: Reset_al=0 together with LD_REG=1, LD_CC=1, LD_BEN=1 -> no register written, NZP=000, BEN=0.
